// File: rtl/iot_event_encoder_pkg.sv
// Shared definitions for the IoT event encoder slice.
//   CNT_W    width of the monitor's active-device count
//   MAX_DEV  largest device population the count can represent
//   EVT_INC / EVT_DEC  on_off encodings for device-up / device-down events
//   evt_t    one reported event {change, on_off, dev_id}
//   cnt_step helper: one non-wrapping step of an active-device count
package iot_pkg;

  localparam int CNT_W   = 8;
  localparam int MAX_DEV = 255;

  localparam logic EVT_INC = 1'b1;
  localparam logic EVT_DEC = 1'b0;

  typedef struct packed {
    logic             change;
    logic             on_off;
    logic [CNT_W-1:0] dev_id;
  } evt_t;

  // Move the count one step in the event's direction, clamped to 0..lim.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic             dir,
                                                input logic [CNT_W-1:0] lim);
    logic [CNT_W-1:0] nxt;
    if (dir == EVT_INC) begin
      nxt = (cnt < lim) ? cnt + {{(CNT_W-1){1'b0}}, 1'b1} : cnt;
    end else begin
      nxt = (cnt != {CNT_W{1'b0}}) ? cnt - {{(CNT_W-1){1'b0}}, 1'b1} : cnt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/iot_event_encoder_if.sv
// Event bus between the device-status producer and the active-device monitor.
//   dev_status  per-device on/off level (1=on)
//   ready       downstream accepts an event this cycle
//   change      one-cycle event strobe
//   on_off      event direction (1=device up, 0=device down)
//   dev_id      device the event reports
//   pending     some device status is still unreported
//   active_cnt  local copy of the monitor count (only with IOT_MIRROR_CNT_EN)
// master: the encoder side; slave: the side supplying status/ready and consuming events.
interface iot_event_encoder_if #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 8
);
  import iot_pkg::*;

  logic [N_DEV-1:0] dev_status;
  logic             ready;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  dev_id;
  logic             pending;
`ifdef IOT_MIRROR_CNT_EN
  logic [CNT_W-1:0] active_cnt;

  modport master (input dev_status, ready,
                  output change, on_off, dev_id, pending, active_cnt);
  modport slave  (output dev_status, ready,
                  input change, on_off, dev_id, pending, active_cnt);
`else
  modport master (input dev_status, ready,
                  output change, on_off, dev_id, pending);
  modport slave  (output dev_status, ready,
                  input change, on_off, dev_id, pending);
`endif

endinterface

// File: rtl/iot_event_encoder_rr_pick.sv
// Combinational round-robin picker.
//   req      per-device request vector
//   start    index that has highest priority this cycle (must be < N_DEV)
//   gnt_vld  some request is set
//   gnt_idx  first set request at or after start, wrapping past N_DEV-1 to 0
//   gnt_oh   one-hot form of gnt_idx (all zero when gnt_vld=0)
module rr_pick #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 8
) (
  input  logic [N_DEV-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic             gnt_vld,
  output logic [ID_W-1:0]  gnt_idx,
  output logic [N_DEV-1:0] gnt_oh
);

  int best_s;
  int best_dist_s;
  int dist_s;

  // Pick the requester with the smallest circular distance from start.
  always_comb begin
    gnt_vld     = 1'b0;
    best_s      = 0;
    best_dist_s = N_DEV;
    dist_s      = 0;
    gnt_oh      = {N_DEV{1'b0}};
    for (int i = 0; i < N_DEV; i++) begin
      dist_s = (i >= int'(start)) ? (i - int'(start)) : (i - int'(start) + N_DEV);
      if (req[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        best_s      = i;
        gnt_vld     = 1'b1;
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    gnt_idx = ID_W'(best_s);
    for (int i = 0; i < N_DEV; i++) begin
      gnt_oh[i] = gnt_vld & (best_s == i);
    end
  end

endmodule

// File: rtl/iot_event_encoder.sv
// Device-side event producer for the active-IoT-devices monitor.
// Compares the live device status vector against a snapshot of what has
// already been reported and emits at most one change/on_off event per cycle,
// serialising simultaneous changes in round-robin order so that the
// monitor's count follows popcount(dev_status).
//   clk   single clock, all state updates on its rising edge
//   rst   synchronous active-high reset
//   bus   iot_event_encoder_if master: dev_status/ready in; change, on_off,
//         dev_id (registered) and pending (combinational) out
// Optional feature macro IOT_MIRROR_CNT_EN adds bus.active_cnt, a registered
// local copy of the monitor count.
module iot_event_encoder #(
  parameter int N_DEV = 8,
  parameter int ID_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  iot_event_encoder_if.master bus
);
  import iot_pkg::*;

  logic [N_DEV-1:0] reported_r;
  logic [ID_W-1:0]  rr_ptr_r;
  logic             change_r;
  logic             on_off_r;
  logic [ID_W-1:0]  dev_id_r;

  logic [N_DEV-1:0] mismatch_s;
  logic             gnt_vld_s;
  logic [ID_W-1:0]  gnt_idx_s;
  logic [N_DEV-1:0] gnt_oh_s;
  logic             grant_s;
  logic             gnt_lvl_s;
  logic [ID_W-1:0]  next_ptr_s;

  // A toggle that returns to its reported level before being granted
  // cancels itself here, so it never produces an event.
  assign mismatch_s = bus.dev_status ^ reported_r;

  rr_pick #(.N_DEV(N_DEV), .ID_W(ID_W)) u_pick (
    .req     (mismatch_s),
    .start   (rr_ptr_r),
    .gnt_vld (gnt_vld_s),
    .gnt_idx (gnt_idx_s),
    .gnt_oh  (gnt_oh_s)
  );

  assign grant_s    = bus.ready & gnt_vld_s;
  assign gnt_lvl_s  = |(bus.dev_status & gnt_oh_s);
  // Pointer moves just past the winner so every other pending device is
  // served before the winner can be granted again.
  assign next_ptr_s = (gnt_idx_s == ID_W'(N_DEV - 1)) ? {ID_W{1'b0}}
                                                      : gnt_idx_s + ID_W'(1);

  // Event output registers, reported snapshot and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      change_r   <= 1'b0;
      on_off_r   <= 1'b0;
      dev_id_r   <= {ID_W{1'b0}};
      reported_r <= {N_DEV{1'b0}};
      rr_ptr_r   <= {ID_W{1'b0}};
    end else if (grant_s) begin
      change_r   <= 1'b1;
      on_off_r   <= gnt_lvl_s;
      dev_id_r   <= gnt_idx_s;
      reported_r <= (reported_r & ~gnt_oh_s) | (bus.dev_status & gnt_oh_s);
      rr_ptr_r   <= next_ptr_s;
    end else begin
      change_r   <= 1'b0;
    end
  end

  assign bus.change  = change_r;
  assign bus.on_off  = on_off_r;
  assign bus.dev_id  = dev_id_r;
  assign bus.pending = |mismatch_s;

`ifdef IOT_MIRROR_CNT_EN
  logic [CNT_W-1:0] active_cnt_r;

  // Mirror of the monitor count, stepped by the event being issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_cnt_r <= {CNT_W{1'b0}};
    end else if (grant_s) begin
      active_cnt_r <= cnt_step(active_cnt_r, gnt_lvl_s, CNT_W'(N_DEV));
    end else begin
      active_cnt_r <= active_cnt_r;
    end
  end

  assign bus.active_cnt = active_cnt_r;
`endif

endmodule

// File: tb/tb_iot_event_encoder.sv
// Directed, table-driven bench for iot_event_encoder (N_DEV=8, ID_W=8).
// A small monitor model accumulates the emitted events into a count.
module tb_iot_event_encoder;
  import iot_pkg::*;

  typedef struct {
    logic       rst;
    logic       ready;
    logic [7:0] ds;
    evt_t       exp;
    logic       exp_pend;
    int         exp_cnt;
  } vec_t;

  localparam int NV = 37;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   mon_cnt;
  vec_t vecs [NV];

  iot_event_encoder_if #(.N_DEV(8), .ID_W(8)) bus ();

  iot_event_encoder #(.N_DEV(8), .ID_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic rdy, input logic [7:0] ds,
                              input logic chg, input logic on, input logic [7:0] id,
                              input logic pend, input int cnt);
    vec_t v;
    v.rst      = r;
    v.ready    = rdy;
    v.ds       = ds;
    v.exp      = '{change: chg, on_off: on, dev_id: id};
    v.exp_pend = pend;
    v.exp_cnt  = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Apply one cycle of inputs, sample just after the edge, update the monitor model.
  task automatic cycle(input logic r, input logic rdy, input logic [7:0] ds);
    rst            = r;
    bus.ready      = rdy;
    bus.dev_status = ds;
    @(posedge clk);
    #1;
    if (r) mon_cnt = 0;
    else if (bus.change) mon_cnt = bus.on_off ? mon_cnt + 1 : mon_cnt - 1;
  endtask

  task automatic check_outputs(input int idx, input evt_t e, input logic pend, input int cnt);
    check("change", idx, {31'd0, bus.change}, {31'd0, e.change});
    check("on_off", idx, {31'd0, bus.on_off}, {31'd0, e.on_off});
    check("dev_id", idx, {24'd0, bus.dev_id}, {24'd0, e.dev_id});
    check("pending", idx, {31'd0, bus.pending}, {31'd0, pend});
    check("mon_cnt", idx, mon_cnt, cnt);
`ifdef IOT_MIRROR_CNT_EN
    check("active_cnt", idx, {24'd0, bus.active_cnt}, mon_cnt);
`endif
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    mon_cnt        = 0;
    rst            = 1'b1;
    bus.ready      = 1'b1;
    bus.dev_status = 8'h00;

    // Reset with everything on, then the full power-up burst.
    vecs[0] = mk(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'd0, 1'b1, 0);
    vecs[1] = mk(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'd0, 1'b1, 0);
    for (int k = 0; k < 8; k++)
      vecs[2+k] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'(k), (k < 7), k + 1);
    vecs[10] = mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'd7, 1'b0, 8);
    // Two rises then one fall.
    vecs[11] = mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 0);
    vecs[12] = mk(1'b0, 1'b1, 8'h24, 1'b1, 1'b1, 8'd2, 1'b1, 1);
    vecs[13] = mk(1'b0, 1'b1, 8'h24, 1'b1, 1'b1, 8'd5, 1'b0, 2);
    vecs[14] = mk(1'b0, 1'b1, 8'h04, 1'b1, 1'b0, 8'd5, 1'b0, 1);
    // Stall with backlog, then drain back-to-back.
    vecs[15] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 0);
    for (int k = 0; k < 5; k++)
      vecs[16+k] = mk(1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 8'd0, 1'b1, 0);
    for (int k = 0; k < 4; k++)
      vecs[21+k] = mk(1'b0, 1'b1, 8'h0F, 1'b1, 1'b1, 8'(k), (k < 3), k + 1);
    vecs[25] = mk(1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 8'd3, 1'b0, 4);
    // Net-zero toggle while stalled.
    vecs[26] = mk(1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 0);
    vecs[27] = mk(1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 8'd0, 1'b1, 0);
    vecs[28] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 0);
    vecs[29] = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 0);
    // Reset mid-burst, burst restarts from device 0.
    vecs[30] = mk(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'd0, 1'b1, 0);
    for (int k = 0; k < 3; k++)
      vecs[31+k] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'(k), 1'b1, k + 1);
    vecs[34] = mk(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 8'd0, 1'b1, 0);
    vecs[35] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'd0, 1'b1, 1);
    vecs[36] = mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 8'd1, 1'b1, 2);

    for (int i = 0; i < NV; i++) begin
      cycle(vecs[i].rst, vecs[i].ready, vecs[i].ds);
      check_outputs(i, vecs[i].exp, vecs[i].exp_pend, vecs[i].exp_cnt);
    end

    // Fairness: bit 0 toggles every cycle while bits 1..7 rise together.
    begin
      logic [7:0] exp_chg;
      logic [7:0] fds;
      logic [7:0] fid [11];
      logic       fchg [11];
      logic       fon [11];
      fid  = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd7, 8'd0, 8'd0};
      fchg = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      fon  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      exp_chg = 8'h00;
      cycle(1'b1, 1'b1, 8'h00);
      check("fair_rst_change", 0, {31'd0, bus.change}, 32'd0);
      for (int c = 0; c < 11; c++) begin
        fds = {7'h7F, ((c % 2) == 0)};
        cycle(1'b0, 1'b1, fds);
        check("fair_change", c, {31'd0, bus.change}, {31'd0, fchg[c]});
        check("fair_dev_id", c, {24'd0, bus.dev_id}, {24'd0, fid[c]});
        check("fair_on_off", c, {31'd0, bus.on_off}, {31'd0, fon[c]});
        if (c < 8 && bus.change) exp_chg[bus.dev_id[2:0]] = 1'b1;
      end
      check("fair_all_granted", 0, {24'd0, exp_chg}, 32'h000000FF);
      check("fair_cnt", 0, mon_cnt, 8);
      check("fair_pending", 0, {31'd0, bus.pending}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
